hci_prio_scheduler: RTL and testbench
=====================================

// Module: hci_prio_scheduler
// PURPOSE
//  Runtime priority scheduler for the cluster's TCDM heterogeneous interconnect: it shares TCDM bandwidth between the core log-interconnect branch and the HWPE/DMA shallow branch.
//  It watches per-port req/gnt handshakes at the interconnect boundary, measures how long the low-priority class has been starved, and drives the interconnect's priority-inversion control.
//  Sits beside the TCDM interconnect wrapper. Its outputs feed the invert_prio / low_prio_max_stall fields of hci_interconnect_ctrl_t.
// PARAMETERS
//  NB_CORES      8   number of core TCDM ports monitored
//  NB_HWPE       1   number of HWPE-branch ports monitored (incl. DMA when it uses HWPE ports)
//  CNT_WIDTH     8   width of stall threshold, boost length and stall counter
//  STAT_WIDTH    32  width of statistics counters (HCI_PRIO_STATS_EN only)
// PORTS
//  clk_i               in   1          cluster clock
//  rst_i               in   1          synchronous reset, active-high
//  core_req_i          in   NB_CORES   core port req
//  core_gnt_i          in   NB_CORES   core port gnt
//  hwpe_req_i          in   NB_HWPE    HWPE-branch port req
//  hwpe_gnt_i          in   NB_HWPE    HWPE-branch port gnt
//  cfg_mode_i          in   2          00 cores-first static, 01 HWPE-first static, 10 adaptive, 11 = 10
//  cfg_max_stall_i     in   CNT_WIDTH  starvation threshold in cycles; 0 disables boosting
//  cfg_boost_len_i     in   CNT_WIDTH  boost and hold-off length in cycles; 0 is treated as 1
//  invert_prio_o       out  1          1 = HWPE branch has priority over cores
//  low_prio_max_stall_o out CNT_WIDTH  registered copy of cfg_max_stall_i
//  state_o             out  2          FSM state: 00 NORMAL, 01 BOOST, 10 HOLDOFF
//  starve_evt_o        out  1          one-cycle pulse on NORMAL->BOOST
// BEHAVIOUR
//  Reset: state=NORMAL, stall_cnt=0, invert_prio_o=0, low_prio_max_stall_o=0, starve_evt_o=0, phase_cnt=0, stats=0.
//  Low-priority class (LP): HWPE when base priority is cores-first (mode 00/10), cores when mode 01.
//  lp_wait = |(lp_req & ~lp_gnt); lp_served = |(lp_req & lp_gnt).
//  stall_cnt (NORMAL only): cleared on lp_served or !lp_wait; otherwise +1, saturating at all-ones.
//  Static modes 00/01: FSM is held in NORMAL; invert_prio_o = (mode==01), registered one cycle after cfg change.
//  Adaptive FSM:
//   NORMAL: invert_prio_o=0. If cfg_max_stall_i!=0, lp_wait, and stall_cnt+1 >= cfg_max_stall_i, then next state is BOOST,
//    phase_cnt=max(cfg_boost_len_i,1), and starve_evt_o=1 for that cycle. Threshold N therefore boosts on the Nth consecutive starved cycle; invert_prio_o rises the cycle after.
//   BOOST: invert_prio_o=1; phase_cnt decrements each cycle; at phase_cnt==1, next state is HOLDOFF with phase_cnt reloaded; stall_cnt=0.
//   HOLDOFF: invert_prio_o=0; stall_cnt frozen at 0; phase_cnt decrements; at 1, next state is NORMAL. This prevents ping-pong.
//  Exact boost duration = max(cfg_boost_len_i,1) cycles of invert_prio_o=1; hold-off is identical.
//  A cfg_mode_i change to static in any state forces NORMAL next cycle and clears stall_cnt/phase_cnt.
//  A cfg_max_stall_i change to 0 in BOOST lets the current boost and hold-off complete.
//  cfg_boost_len_i is sampled only on entry to BOOST/HOLDOFF.
//  Simultaneous lp_served and threshold hit: served wins, so there is no boost and stall_cnt=0.
//  rst_i mid-BOOST returns all outputs to reset values on the next edge.
//  All outputs are registered. There are no combinational paths from inputs to outputs.
// CONFIGURATION
//  HCI_PRIO_STATS_EN defined: adds out ports boost_cnt_o[STAT_WIDTH] and lp_stall_cycles_o[STAT_WIDTH].
//   boost_cnt_o counts NORMAL->BOOST transitions. lp_stall_cycles_o counts cycles with lp_wait=1. Both saturate and are cleared only by rst_i.
//  HCI_PRIO_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  Mode 10, max_stall=4, boost_len=3, HWPE req held, gnt=0: starve_evt_o pulses on the 4th cycle, invert_prio_o=1 for exactly 3 cycles, 0 for 3 HOLDOFF cycles, then NORMAL and recount.
//  Mode 10, max_stall=4: HWPE gnt=1 on every 3rd cycle -> stall_cnt never reaches 4; invert_prio_o stays 0 and there are no starve_evt_o pulses.
//  Mode 01, cores req held with no gnt -> invert_prio_o=1 constantly and state_o=00. Switching to mode 00 drops invert_prio_o to 0 one cycle later.
//  Mode 10, max_stall=0 with HWPE starved for 1000 cycles -> no boost. max_stall=255 with boost_len=0 -> boost of 1 cycle after 255 stalls, and the counter saturates without wrapping.
//  rst_i asserted in the 2nd BOOST cycle -> next cycle all outputs at reset values and state_o=00.
//  With HCI_PRIO_STATS_EN, scenario 1 run twice -> boost_cnt_o=2 and lp_stall_cycles_o equal to the starved-cycle count.

Source files
------------

// File: rtl/hci_prio_scheduler.sv
// hci_prio_scheduler: runtime priority scheduler for the TCDM heterogeneous
// interconnect. Watches core / HWPE-branch req/gnt handshakes, measures how
// long the low-priority class has been starved and drives invert_prio_o plus
// low_prio_max_stall_o for hci_interconnect_ctrl_t.
//
// Optional feature macro: HCI_PRIO_STATS_EN
//   defined   -> adds the STAT_WIDTH parameter and the saturating statistics
//                outputs boost_cnt_o and lp_stall_cycles_o
//   undefined -> statistics ports and counters are absent
module hci_prio_scheduler #(
   parameter int unsigned NB_CORES   = 8,
   parameter int unsigned NB_HWPE    = 1,
   parameter int unsigned CNT_WIDTH  = 8
`ifdef HCI_PRIO_STATS_EN
   ,
   parameter int unsigned STAT_WIDTH = 32
`endif
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NB_CORES-1:0]   core_req_i,
   input  logic [NB_CORES-1:0]   core_gnt_i,
   input  logic [NB_HWPE-1:0]    hwpe_req_i,
   input  logic [NB_HWPE-1:0]    hwpe_gnt_i,
   input  logic [1:0]            cfg_mode_i,
   input  logic [CNT_WIDTH-1:0]  cfg_max_stall_i,
   input  logic [CNT_WIDTH-1:0]  cfg_boost_len_i,
   output logic                  invert_prio_o,
   output logic [CNT_WIDTH-1:0]  low_prio_max_stall_o,
   output logic [1:0]            state_o,
   output logic                  starve_evt_o
`ifdef HCI_PRIO_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] boost_cnt_o,
   output logic [STAT_WIDTH-1:0] lp_stall_cycles_o
`endif
);

   localparam int unsigned     IncWidth = CNT_WIDTH + 1;
   localparam logic [1:0]      ModeHwpeFirst = 2'b01;

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'b00,
      ST_BOOST   = 2'b01,
      ST_HOLDOFF = 2'b10
   } state_t;

   state_t                state_q;
   logic [CNT_WIDTH-1:0]  stall_cnt_q;
   logic [CNT_WIDTH-1:0]  phase_cnt_q;

   logic                  adaptive;
   logic                  lp_wait;
   logic                  lp_served;
   logic [IncWidth-1:0]   stall_inc;
   logic                  threshold_hit;
   logic                  stall_sat;
   logic [CNT_WIDTH-1:0]  boost_len;

   // Low-priority class selection, starvation threshold and phase length.
   always_comb begin
      adaptive  = cfg_mode_i[1];
      lp_wait   = 1'b0;
      lp_served = 1'b0;
      if (cfg_mode_i == ModeHwpeFirst) begin
         lp_wait   = |(core_req_i & ~core_gnt_i);
         lp_served = |(core_req_i &  core_gnt_i);
      end else begin
         lp_wait   = |(hwpe_req_i & ~hwpe_gnt_i);
         lp_served = |(hwpe_req_i &  hwpe_gnt_i);
      end
      // one extra bit so a saturated counter still compares above any threshold
      stall_inc     = IncWidth'(stall_cnt_q) + IncWidth'(1);
      stall_sat     = (stall_cnt_q == {CNT_WIDTH{1'b1}});
      // a grant to any low-priority port in the same cycle suppresses the boost
      threshold_hit = (cfg_max_stall_i != '0) && lp_wait && !lp_served &&
                      (stall_inc >= IncWidth'(cfg_max_stall_i));
      boost_len     = (cfg_boost_len_i == '0) ? CNT_WIDTH'(1) : cfg_boost_len_i;
   end

   // Priority FSM with stall/phase counters and registered control outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q              <= ST_NORMAL;
         stall_cnt_q          <= '0;
         phase_cnt_q          <= '0;
         invert_prio_o        <= 1'b0;
         low_prio_max_stall_o <= '0;
         starve_evt_o         <= 1'b0;
      end else begin
         starve_evt_o         <= 1'b0;
         low_prio_max_stall_o <= cfg_max_stall_i;
         if (!adaptive) begin
            // static modes pin the FSM and expose the base priority directly
            state_q       <= ST_NORMAL;
            stall_cnt_q   <= '0;
            phase_cnt_q   <= '0;
            invert_prio_o <= (cfg_mode_i == ModeHwpeFirst);
         end else begin
            case (state_q)
               ST_NORMAL: begin
                  if (threshold_hit) begin
                     state_q       <= ST_BOOST;
                     phase_cnt_q   <= boost_len;
                     stall_cnt_q   <= '0;
                     starve_evt_o  <= 1'b1;
                     invert_prio_o <= 1'b1;
                  end else begin
                     invert_prio_o <= 1'b0;
                     if (lp_served || !lp_wait) begin
                        stall_cnt_q <= '0;
                     end else if (!stall_sat) begin
                        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
                     end
                  end
               end
               ST_BOOST: begin
                  stall_cnt_q <= '0;
                  if (phase_cnt_q == CNT_WIDTH'(1)) begin
                     state_q       <= ST_HOLDOFF;
                     phase_cnt_q   <= boost_len;
                     invert_prio_o <= 1'b0;
                  end else begin
                     phase_cnt_q   <= phase_cnt_q - CNT_WIDTH'(1);
                     invert_prio_o <= 1'b1;
                  end
               end
               ST_HOLDOFF: begin
                  // counting resumes only once back in NORMAL, preventing ping-pong
                  stall_cnt_q   <= '0;
                  invert_prio_o <= 1'b0;
                  if (phase_cnt_q == CNT_WIDTH'(1)) begin
                     state_q     <= ST_NORMAL;
                     phase_cnt_q <= '0;
                  end else begin
                     phase_cnt_q <= phase_cnt_q - CNT_WIDTH'(1);
                  end
               end
               default: begin
                  state_q       <= ST_NORMAL;
                  stall_cnt_q   <= '0;
                  phase_cnt_q   <= '0;
                  invert_prio_o <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state_o = state_q;

`ifdef HCI_PRIO_STATS_EN
   logic boost_start;

   // NORMAL->BOOST transition qualifier for the boost counter.
   always_comb begin
      boost_start = adaptive && (state_q == ST_NORMAL) && threshold_hit;
   end

   // Saturating statistics counters, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         boost_cnt_o       <= '0;
         lp_stall_cycles_o <= '0;
      end else begin
         if (boost_start && (boost_cnt_o != {STAT_WIDTH{1'b1}})) begin
            boost_cnt_o <= boost_cnt_o + STAT_WIDTH'(1);
         end
         if (lp_wait && (lp_stall_cycles_o != {STAT_WIDTH{1'b1}})) begin
            lp_stall_cycles_o <= lp_stall_cycles_o + STAT_WIDTH'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hci_prio_scheduler.sv
// Self-checking bench for hci_prio_scheduler: a cycle-level behavioural model
// is compared against the DUT on every cycle, and directed scenarios pin
// the model with hand-computed timeline expectations.
module tb_hci_prio_scheduler;

   localparam int unsigned NB_CORES  = 8;
   localparam int unsigned NB_HWPE   = 2;
   localparam int unsigned CNT_WIDTH = 8;
   localparam int          NREC      = 1300;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NB_CORES-1:0]   core_req, core_gnt;
   logic [NB_HWPE-1:0]    hwpe_req, hwpe_gnt;
   logic [1:0]            mode;
   logic [CNT_WIDTH-1:0]  max_stall, boost_len;
   logic                  invert_prio;
   logic [CNT_WIDTH-1:0]  max_stall_q;
   logic [1:0]            state;
   logic                  starve_evt;
`ifdef HCI_PRIO_STATS_EN
   logic [31:0]           boost_cnt, lp_stall_cycles;
`endif

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   hci_prio_scheduler #(
      .NB_CORES  (NB_CORES),
      .NB_HWPE   (NB_HWPE),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .core_req_i           (core_req),
      .core_gnt_i           (core_gnt),
      .hwpe_req_i           (hwpe_req),
      .hwpe_gnt_i           (hwpe_gnt),
      .cfg_mode_i           (mode),
      .cfg_max_stall_i      (max_stall),
      .cfg_boost_len_i      (boost_len),
      .invert_prio_o        (invert_prio),
      .low_prio_max_stall_o (max_stall_q),
      .state_o              (state),
      .starve_evt_o         (starve_evt)
`ifdef HCI_PRIO_STATS_EN
      ,
      .boost_cnt_o          (boost_cnt),
      .lp_stall_cycles_o    (lp_stall_cycles)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // run: consecutive starved NORMAL cycles; boost_left / hold_left: cycles of
   // boost / hold-off still to be shown after the current edge.
   int          m_run = 0, m_boost_left = 0, m_hold_left = 0, m_len = 1;
   logic        m_inv = 1'b0, m_evt = 1'b0;
   logic [1:0]  m_state = 2'b00;
   logic [7:0]  m_max = 8'd0;
   longint      m_boosts = 0, m_waits = 0;
   bit          m_w, m_s;

   always @(posedge clk) begin
      if (mode == 2'b01) begin
         m_w = |(core_req & ~core_gnt);
         m_s = |(core_req & core_gnt);
      end else begin
         m_w = |(hwpe_req & ~hwpe_gnt);
         m_s = |(hwpe_req & hwpe_gnt);
      end
      m_len = (boost_len == 0) ? 1 : int'(boost_len);
      if (rst) begin
         m_run = 0; m_boost_left = 0; m_hold_left = 0;
         m_inv = 1'b0; m_evt = 1'b0; m_state = 2'b00; m_max = 8'd0;
         m_boosts = 0; m_waits = 0;
      end else begin
         m_max = max_stall;
         m_evt = 1'b0;
         if (m_w && m_waits < 64'hFFFF_FFFF) m_waits++;
         if (!mode[1]) begin
            m_run = 0; m_boost_left = 0; m_hold_left = 0;
         end else if (m_boost_left > 0) begin
            m_boost_left--;
            if (m_boost_left == 0) m_hold_left = m_len;
         end else if (m_hold_left > 0) begin
            m_hold_left--;
         end else if (m_s || !m_w) begin
            m_run = 0;
         end else if (max_stall != 0 && m_run + 1 >= int'(max_stall)) begin
            m_boost_left = m_len;
            m_run = 0;
            m_evt = 1'b1;
            if (m_boosts < 64'hFFFF_FFFF) m_boosts++;
         end else if (m_run < 255) begin
            m_run++;
         end
         m_state = (m_boost_left > 0) ? 2'b01 : ((m_hold_left > 0) ? 2'b10 : 2'b00);
         m_inv   = (m_boost_left > 0) || (mode == 2'b01);
      end
   end

   // Per-cycle comparison of DUT against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_invert", 64'(invert_prio), 64'(m_inv));
         chk("model_state",  64'(state),       64'(m_state));
         chk("model_evt",    64'(starve_evt),  64'(m_evt));
         chk("model_max",    64'(max_stall_q), 64'(m_max));
`ifdef HCI_PRIO_STATS_EN
         chk("model_boost_cnt", 64'(boost_cnt),       64'(m_boosts));
         chk("model_lp_stall",  64'(lp_stall_cycles), 64'(m_waits));
`endif
      end
   end

   // ---------------- recording helpers ----------------
   logic       inv_seen [0:NREC-1];
   logic       evt_seen [0:NREC-1];
   logic [1:0] st_seen  [0:NREC-1];
   logic [7:0] mx_seen  [0:NREC-1];

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic sample(input int k);
      inv_seen[k] = invert_prio;
      evt_seen[k] = starve_evt;
      st_seen[k]  = state;
      mx_seen[k]  = max_stall_q;
   endtask

   task automatic rec(input int from, input int to);
      for (int k = from; k <= to; k++) begin
         step();
         sample(k);
      end
   endtask

   function automatic int count_evt(input int from, input int to);
      int n = 0;
      for (int k = from; k <= to; k++) if (evt_seen[k] === 1'b1) n++;
      return n;
   endfunction

   function automatic int count_inv(input int from, input int to);
      int n = 0;
      for (int k = from; k <= to; k++) if (inv_seen[k] === 1'b1) n++;
      return n;
   endfunction

   function automatic int first_evt(input int from, input int to);
      for (int k = from; k <= to; k++) if (evt_seen[k] === 1'b1) return k;
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      core_req = '0; core_gnt = '0; hwpe_req = '0; hwpe_gnt = '0;
      mode = 2'b00; max_stall = '0; boost_len = '0;
      step();
      rst = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      do_reset();
      chk_en = 1'b1;
      chk("reset_invert", 64'(invert_prio), 64'd0);
      chk("reset_state",  64'(state),       64'd0);
      chk("reset_evt",    64'(starve_evt),  64'd0);
      chk("reset_max",    64'(max_stall_q), 64'd0);

      // starved HWPE, threshold 4, boost 3: boost at edge 4, recount after hold-off
      do_reset();
      mode = 2'b10; max_stall = 8'd4; boost_len = 8'd3; hwpe_req = 2'b01;
      rec(1, 20);
      chk("s1_first_evt",  64'(first_evt(1, 20)), 64'd4);
      chk("s1_evt_count",  64'(count_evt(1, 13)), 64'd1);
      chk("s1_inv_len",    64'(count_inv(1, 9)),  64'd3);
      chk("s1_inv_at4",    64'(inv_seen[4]),      64'd1);
      chk("s1_inv_at7",    64'(inv_seen[7]),      64'd0);
      chk("s1_hold_at7",   64'(st_seen[7]),       64'd2);
      chk("s1_hold_at9",   64'(st_seen[9]),       64'd2);
      chk("s1_normal_10",  64'(st_seen[10]),      64'd0);
      chk("s1_second_evt", 64'(evt_seen[14]),     64'd1);
`ifdef HCI_PRIO_STATS_EN
      chk("s1_boost_cnt",  64'(boost_cnt),        64'd2);
      chk("s1_lp_stall",   64'(lp_stall_cycles),  64'd20);
`endif

      // threshold dropped to 0 mid-boost: boost and hold-off still complete
      do_reset();
      mode = 2'b10; max_stall = 8'd4; boost_len = 8'd3; hwpe_req = 2'b01;
      rec(1, 5);
      max_stall = 8'd0;
      rec(6, 15);
      chk("s1b_inv_len",   64'(count_inv(1, 15)), 64'd3);
      chk("s1b_evt_count", 64'(count_evt(1, 15)), 64'd1);
      chk("s1b_hold_at8",  64'(st_seen[8]),       64'd2);

      // HWPE granted every 3rd cycle: never starved long enough
      do_reset();
      mode = 2'b10; max_stall = 8'd4; boost_len = 8'd3; hwpe_req = 2'b01;
      for (int k = 1; k <= 30; k++) begin
         hwpe_gnt = (k % 3 == 0) ? 2'b01 : 2'b00;
         step();
         sample(k);
      end
      hwpe_gnt = 2'b00;
      chk("s2_no_evt", 64'(count_evt(1, 30)), 64'd0);
      chk("s2_no_inv", 64'(count_inv(1, 30)), 64'd0);

      // static HWPE-first, then back to cores-first
      do_reset();
      mode = 2'b01; core_req = 8'hFF;
      rec(1, 10);
      chk("s3_inv_first", 64'(inv_seen[1]),      64'd1);
      chk("s3_inv_all",   64'(count_inv(1, 10)), 64'd10);
      chk("s3_state",     64'(st_seen[10]),      64'd0);
      chk("s3_no_evt",    64'(count_evt(1, 10)), 64'd0);
      mode = 2'b00;
      rec(11, 12);
      chk("s3_inv_drop",  64'(inv_seen[11]),     64'd0);

      // threshold 0 disables boosting; then saturated counter and 1-cycle boost
      do_reset();
      core_req = '0;
      mode = 2'b10; max_stall = 8'd0; boost_len = 8'd3; hwpe_req = 2'b01;
      rec(1, 1000);
      chk("s4_no_evt", 64'(count_evt(1, 1000)), 64'd0);
      chk("s4_no_inv", 64'(count_inv(1, 1000)), 64'd0);
      max_stall = 8'd255; boost_len = 8'd2;
      rec(1001, 1005);
      chk("s4_sat_evt", 64'(evt_seen[1001]), 64'd1);
      hwpe_req = 2'b00;
      rec(1006, 1006);
      hwpe_req = 2'b01; boost_len = 8'd0;
      rec(1007, 1280);
      chk("s4_evt_255",  64'(first_evt(1007, 1280)), 64'd1261);
      chk("s4_inv_1cyc", 64'(count_inv(1007, 1280)), 64'd1);
      chk("s4_hold",     64'(st_seen[1262]),         64'd2);
      chk("s4_normal",   64'(st_seen[1263]),         64'd0);

      // reset during the second boost cycle
      do_reset();
      mode = 2'b10; max_stall = 8'd2; boost_len = 8'd5; hwpe_req = 2'b01;
      rec(1, 3);
      chk("s5_boost1", 64'(st_seen[2]), 64'd1);
      chk("s5_boost2", 64'(st_seen[3]), 64'd1);
      rst = 1'b1;
      rec(4, 4);
      rst = 1'b0;
      chk("s5_rst_inv",   64'(inv_seen[4]), 64'd0);
      chk("s5_rst_state", 64'(st_seen[4]),  64'd0);
      chk("s5_rst_evt",   64'(evt_seen[4]), 64'd0);
      chk("s5_rst_max",   64'(mx_seen[4]),  64'd0);

      // same-cycle grant on one HWPE port beats the threshold
      do_reset();
      mode = 2'b10; max_stall = 8'd3; boost_len = 8'd2; hwpe_req = 2'b11;
      rec(1, 2);
      hwpe_gnt = 2'b01;
      rec(3, 3);
      hwpe_gnt = 2'b00;
      rec(4, 8);
      chk("s6_no_early", 64'(count_evt(1, 5)), 64'd0);
      chk("s6_evt_at6",  64'(first_evt(1, 8)), 64'd6);

      // switching to static mid-boost aborts it and clears the stall count
      do_reset();
      mode = 2'b10; max_stall = 8'd2; boost_len = 8'd4; hwpe_req = 2'b01;
      rec(1, 3);
      mode = 2'b00;
      rec(4, 6);
      chk("s7_abort_state", 64'(st_seen[4]),  64'd0);
      chk("s7_abort_inv",   64'(inv_seen[4]), 64'd0);
      mode = 2'b10;
      rec(7, 10);
      chk("s7_recount", 64'(first_evt(7, 10)), 64'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
